// File: rtl/alu_mdu_seq.sv
// Multi-cycle execute-stage ALU with valid/ready handshake, shift-add multiplier
// and restoring divider returning HI/LO words plus registered flags.
module alu_mdu_seq #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero_flag,
    output logic             ovf_flag,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Iteration datapath: acc_hi = partial product HI / remainder,
    // acc_lo = multiplier / dividend shifting into quotient.
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd_b;
    logic             neg_lo, neg_hi, ovf_pend;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH-1:0]   sum, diff, alu_res;
    logic               alu_ovf;
    logic               is_mul, is_div, op_sgn, a_neg, b_neg;
    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] mul_next, mul_fin;
    logic               div_ok;
    logic [WIDTH-1:0]   rem_next, quo_next, quo_fin, rem_fin;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    assign a_s    = data_1;
    assign b_s    = data_2;
    assign sum    = data_1 + data_2;
    assign diff   = data_1 - data_2;
    assign a_neg  = data_1[WIDTH-1];
    assign b_neg  = data_2[WIDTH-1];
    assign is_mul = (op == OP_W'(8)) || (op == OP_W'(9));
    assign is_div = (op == OP_W'(10)) || (op == OP_W'(11));
    assign op_sgn = (op == OP_W'(9)) || (op == OP_W'(11));

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_W'(0): begin
                alu_res = sum;
                alu_ovf = (a_neg == b_neg) && (sum[WIDTH-1] != a_neg);
            end
            OP_W'(1): begin
                alu_res = diff;
                alu_ovf = (a_neg != b_neg) && (diff[WIDTH-1] == b_neg);
            end
            OP_W'(2): alu_res = data_1 & data_2;
            OP_W'(3): alu_res = data_1 | data_2;
            OP_W'(4): alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_W'(5): alu_res = {{(WIDTH-1){1'b0}}, (data_1 < data_2)};
            OP_W'(6): alu_res = data_1 ^ data_2;
            OP_W'(7): alu_res = ~(data_1 | data_2);
            default:  alu_res = '0;
        endcase
    end

    // One iteration step; the last step writes the sign-corrected result directly.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : {(WIDTH+1){1'b0}});
    assign mul_next  = {mul_sum, acc_lo[WIDTH-1:1]};
    assign mul_fin   = cneg2(mul_next, neg_lo);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd_b};
    assign div_ok    = ~div_trial[WIDTH];
    assign rem_next  = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign quo_next  = {acc_lo[WIDTH-2:0], div_ok};
    assign quo_fin   = cneg(quo_next, neg_lo);
    assign rem_fin   = cneg(rem_next, neg_hi);

    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            acc_hi   <= '0;
            acc_lo   <= is_mul ? mag(data_2, op_sgn) : mag(data_1, op_sgn);
            opnd_b   <= is_mul ? mag(data_1, op_sgn) : mag(data_2, op_sgn);
            neg_lo   <= op_sgn && (a_neg ^ b_neg);
            neg_hi   <= op_sgn && a_neg;
            ovf_pend <= op_sgn && (data_1 == MIN_VAL) && (data_2 == '1);
        end else if (state == MUL) begin
            {acc_hi, acc_lo} <= mul_next;
        end else if (state == DIV) begin
            acc_hi <= rem_next;
            acc_lo <= quo_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            result      <= '0;
            result_hi   <= '0;
            zero_flag   <= 1'b0;
            ovf_flag    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    in_ready <= 1'b0;
                    cnt      <= '0;
                    if (is_mul) begin
                        state <= MUL;
                    end else if (is_div && data_2 == '0) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        result      <= '1;
                        result_hi   <= data_1;
                        zero_flag   <= 1'b0;
                        ovf_flag    <= 1'b0;
                        div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        state <= DIV;
                    end else begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        result      <= alu_res;
                        result_hi   <= '0;
                        zero_flag   <= (op < OP_W'(12)) && (alu_res == '0);
                        ovf_flag    <= alu_ovf;
                        div_by_zero <= 1'b0;
                    end
                end
                MUL: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        result      <= mul_fin[WIDTH-1:0];
                        result_hi   <= mul_fin[2*WIDTH-1:WIDTH];
                        zero_flag   <= (mul_fin[WIDTH-1:0] == '0);
                        ovf_flag    <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                DIV: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        result      <= quo_fin;
                        result_hi   <= rem_fin;
                        zero_flag   <= (quo_fin == '0);
                        ovf_flag    <= ovf_pend;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq at WIDTH=32: latency, arithmetic, divide corners,
// backpressure and asynchronous reset mid-multiply.
module tb_alu_mdu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] data_1, data_2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result, result_hi;
    logic        zero_flag, ovf_flag, div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    logic [31:0] held_lo, held_hi;

    alu_mdu_seq #(.WIDTH(32), .OP_W(4), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .data_1(data_1), .data_2(data_2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi),
        .zero_flag(zero_flag), .ovf_flag(ovf_flag), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, then count edges from the accept edge until out_valid is seen.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int l);
        @(negedge clk);
        op = o; data_1 = a; data_2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_1 = 32'hDEAD_BEEF; data_2 = 32'h1234_5678; op = 4'd0;
        l = 1;
        while (!out_valid && l < 100) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] lo, input logic [31:0] hi,
                              input logic z, input logic o, input logic dz);
        check({tag, " result"}, result, lo);
        check({tag, " result_hi"}, result_hi, hi);
        check({tag, " flags z/ovf/dbz"}, {29'd0, zero_flag, ovf_flag, div_by_zero},
              {29'd0, z, o, dz});
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " out_valid after consume"}, {31'd0, out_valid}, 32'd0);
        check({tag, " in_ready after consume"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 4'd0; data_1 = '0; data_2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset result_hi", result_hi, 32'd0);
        check("reset flags", {29'd0, zero_flag, ovf_flag, div_by_zero}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, lat);
        check("ADD latency", lat, 1);
        expect_out("ADD ovf", 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0);
        consume("ADD");

        run_op(4'd1, 32'd5, 32'd5, lat);
        expect_out("SUB 5-5", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        consume("SUB");

        run_op(4'd4, 32'hFFFF_FFFF, 32'd1, lat);
        expect_out("SLT", 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
        consume("SLT");

        run_op(4'd5, 32'hFFFF_FFFF, 32'd1, lat);
        expect_out("SLTU", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        consume("SLTU");

        run_op(4'd1, 32'h8000_0000, 32'd1, lat);
        expect_out("SUB ovf", 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0);
        consume("SUBovf");

        run_op(4'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat);
        check("XOR", result, 32'hFF00_FF00);
        consume("XOR");

        run_op(4'd7, 32'd0, 32'd0, lat);
        check("NOR", result, 32'hFFFF_FFFF);
        consume("NOR");

        run_op(4'd13, 32'd5, 32'd5, lat);
        check("op13 latency", lat, 1);
        expect_out("op13", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        consume("op13");

        run_op(4'd9, 32'hFFFF_FFFD, 32'd7, lat);
        check("MULT latency", lat, 33);
        expect_out("MULT -3*7", 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        consume("MULT");

        run_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        expect_out("MULTU max", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        consume("MULTU");

        run_op(4'd11, 32'hFFFF_FFF9, 32'd2, lat);
        check("DIV latency", lat, 33);
        expect_out("DIV -7/2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        consume("DIV");

        run_op(4'd11, 32'd7, 32'hFFFF_FFFE, lat);
        expect_out("DIV 7/-2", 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 1'b0);
        consume("DIV2");

        run_op(4'd10, 32'd100, 32'd7, lat);
        expect_out("DIVU 100/7", 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
        consume("DIVU");

        run_op(4'd11, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        expect_out("DIV MIN/-1", 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0);
        consume("DIVMIN");

        // Backpressure on the divide-by-zero result; a request offered in DONE must be ignored.
        run_op(4'd10, 32'd9, 32'd0, lat);
        check("DIVU/0 latency", lat, 1);
        expect_out("DIVU 9/0", 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b0, 1'b1);
        held_lo = result;
        held_hi = result_hi;
        @(negedge clk);
        in_valid = 1'b1; op = 4'd0; data_1 = 32'd1; data_2 = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp out_valid", {31'd0, out_valid}, 32'd1);
            check("bp in_ready", {31'd0, in_ready}, 32'd0);
            check("bp result", result, held_lo);
            check("bp result_hi", result_hi, held_hi);
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume("bp");

        // Asynchronous reset during MULT iteration 10.
        @(negedge clk);
        op = 4'd9; data_1 = 32'd123; data_2 = 32'd456; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst result", result, 32'd0);
        check("midrst result_hi", result_hi, 32'd0);
        check("midrst flags", {29'd0, zero_flag, ovf_flag, div_by_zero}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op(4'd0, 32'd2, 32'd3, lat);
        check("post-reset ADD latency", lat, 1);
        expect_out("post-reset ADD", 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
        consume("postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
